// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS datapath and its control sequencer.
package mips_pkg;

   // FSM state encoding, kept as plain constants so legacy code can compare raw values
   typedef logic [2:0] state_t;
   localparam state_t StIdle      = 3'd0;
   localparam state_t StFetch     = 3'd1;
   localparam state_t StDecode    = 3'd2;
   localparam state_t StExecute   = 3'd3;
   localparam state_t StWriteback = 3'd4;
   localparam state_t StHalt      = 3'd5;
   localparam state_t StError     = 3'd6;

   // ALU operation codes
   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluSub = 2'b01;
   localparam logic [1:0] AluAnd = 2'b10;
   localparam logic [1:0] AluSlt = 2'b11;

   // PC source select
   localparam logic [1:0] PcPlus4  = 2'd0;
   localparam logic [1:0] PcRs     = 2'd1;
   localparam logic [1:0] PcJump   = 2'd2;
   localparam logic [1:0] PcBranch = 2'd3;

   // Primary opcodes
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpBlt   = 6'b001010;
   localparam logic [5:0] OpBgt   = 6'b001011;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpHalt  = 6'b111111;

   // R-type function codes
   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnSlt = 6'b101010;
   localparam logic [5:0] FnJr  = 6'b001000;

   // Error codes
   localparam logic [1:0] ErrNone    = 2'd0;
   localparam logic [1:0] ErrIllegal = 2'd1;
   localparam logic [1:0] ErrTimeout = 2'd2;

   // Instruction class as seen by the sequencer
   typedef enum logic [2:0] {
      ClsAlu, ClsBeq, ClsBne, ClsBlt, ClsBgt, ClsJ, ClsJr, ClsHalt
   } instr_class_e;

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction classifier: opcode/funct -> class and ALU controls.
module mips_decode
   import mips_pkg::*;
(
   input  logic [5:0]   opcode_i,
   input  logic [5:0]   funct_i,
   output instr_class_e cls_o,
   output logic [1:0]   alu_op_o,
   output logic         alu_src_o,
   output logic         alu_swap_o,
   output logic         illegal_o,
   output logic         is_branch_o,
   output logic         is_halt_o
);

   // Classify the instruction; anything not listed is flagged illegal
   always_comb begin
      cls_o       = ClsAlu;
      alu_op_o    = AluAdd;
      alu_src_o   = 1'b0;
      alu_swap_o  = 1'b0;
      illegal_o   = 1'b0;
      is_branch_o = 1'b0;
      is_halt_o   = 1'b0;
      case (opcode_i)
         OpRtype: begin
            case (funct_i)
               FnAdd: alu_op_o = AluAdd;
               FnSub: alu_op_o = AluSub;
               FnAnd: alu_op_o = AluAnd;
               FnSlt: alu_op_o = AluSlt;
               FnJr: begin
                  cls_o       = ClsJr;
                  is_branch_o = 1'b1;
               end
               default: illegal_o = 1'b1;
            endcase
         end
         OpAddi: alu_src_o = 1'b1;
         OpBeq: begin
            cls_o       = ClsBeq;
            alu_op_o    = AluSub;
            is_branch_o = 1'b1;
         end
         OpBne: begin
            cls_o       = ClsBne;
            alu_op_o    = AluSub;
            is_branch_o = 1'b1;
         end
         OpBlt: begin
            cls_o       = ClsBlt;
            alu_op_o    = AluSlt;
            is_branch_o = 1'b1;
         end
         OpBgt: begin
            // a > b evaluated as b < a by swapping operands
            cls_o       = ClsBgt;
            alu_op_o    = AluSlt;
            alu_swap_o  = 1'b1;
            is_branch_o = 1'b1;
         end
         OpJ: begin
            cls_o       = ClsJ;
            is_branch_o = 1'b1;
         end
         OpHalt: begin
            cls_o     = ClsHalt;
            is_halt_o = 1'b1;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer for the MIPS datapath.
module mips_mc_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned IMEM_TIMEOUT = 15,
   parameter int unsigned INSTRET_W    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 imem_req,
   input  logic                 imem_ack,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          ir,
   output logic                 alu_src,
   output logic                 alu_swap,
   output logic [1:0]           alu_op,
   input  logic                 alu_zero,
   input  logic                 alu_lt,
   output logic                 reg_write,
   output logic [1:0]           pc_sel,
   output logic                 pc_we,
   output logic [2:0]           state,
   output logic [INSTRET_W-1:0] instret,
   output logic                 halted,
   output logic                 error,
   output logic [1:0]           err_code
);

   // Counter value seen in the last permitted FETCH cycle
   localparam logic [7:0] TmoLast = 8'(IMEM_TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic [31:0]            ir_q, ir_d;
   logic [7:0]             tmo_q, tmo_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic                   halted_q, halted_d;
   logic                   error_q, error_d;
   logic [1:0]             err_code_q, err_code_d;

   instr_class_e dec_cls;
   logic [1:0]   dec_alu_op;
   logic         dec_alu_src, dec_alu_swap, dec_illegal, dec_is_branch, dec_is_halt;

   mips_decode u_decode (
      .opcode_i    (ir_q[31:26]),
      .funct_i     (ir_q[5:0]),
      .cls_o       (dec_cls),
      .alu_op_o    (dec_alu_op),
      .alu_src_o   (dec_alu_src),
      .alu_swap_o  (dec_alu_swap),
      .illegal_o   (dec_illegal),
      .is_branch_o (dec_is_branch),
      .is_halt_o   (dec_is_halt)
   );

   // Next-state, timeout, retire and sticky-status logic
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      tmo_d      = tmo_q;
      instret_d  = instret_q;
      halted_d   = halted_q;
      error_d    = error_q;
      err_code_d = err_code_q;
      case (state_q)
         StIdle: if (start) state_d = StFetch;
         StFetch: begin
            if (imem_ack) begin
               // ack takes priority over an expiring timeout
               ir_d    = imem_rdata;
               tmo_d   = 8'd0;
               state_d = StDecode;
            end else if (tmo_q == TmoLast) begin
               tmo_d      = 8'd0;
               error_d    = 1'b1;
               err_code_d = ErrTimeout;
               state_d    = StError;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         StDecode: begin
            if (dec_illegal) begin
               error_d    = 1'b1;
               err_code_d = ErrIllegal;
               state_d    = StError;
            end else begin
               state_d = StExecute;
            end
         end
         StExecute: begin
            if (dec_is_halt) begin
               halted_d  = 1'b1;
               instret_d = instret_q + INSTRET_W'(1);
               state_d   = StHalt;
            end else if (dec_is_branch) begin
               instret_d = instret_q + INSTRET_W'(1);
               state_d   = StFetch;
            end else begin
               state_d = StWriteback;
            end
         end
         StWriteback: begin
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = StFetch;
         end
         default: ;
      endcase
   end

   // Per-state datapath controls; branch outcome resolved from live ALU flags
   always_comb begin
      imem_req  = (state_q == StFetch);
      alu_src   = 1'b0;
      alu_swap  = 1'b0;
      alu_op    = AluAdd;
      reg_write = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = PcPlus4;
      case (state_q)
         StExecute: begin
            alu_src  = dec_alu_src;
            alu_swap = dec_alu_swap;
            alu_op   = dec_alu_op;
            pc_we    = dec_is_branch;
            case (dec_cls)
               ClsBeq:  pc_sel = alu_zero  ? PcBranch : PcPlus4;
               ClsBne:  pc_sel = !alu_zero ? PcBranch : PcPlus4;
               ClsBlt:  pc_sel = alu_lt    ? PcBranch : PcPlus4;
               ClsBgt:  pc_sel = alu_lt    ? PcBranch : PcPlus4;
               ClsJ:    pc_sel = PcJump;
               ClsJr:   pc_sel = PcRs;
               default: pc_sel = PcPlus4;
            endcase
         end
         StWriteback: begin
            // ALU controls held so the write-back value stays stable
            alu_src   = dec_alu_src;
            alu_swap  = dec_alu_swap;
            alu_op    = dec_alu_op;
            reg_write = 1'b1;
            pc_we     = 1'b1;
         end
         default: ;
      endcase
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         ir_q       <= 32'd0;
         tmo_q      <= 8'd0;
         instret_q  <= '0;
         halted_q   <= 1'b0;
         error_q    <= 1'b0;
         err_code_q <= ErrNone;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         tmo_q      <= tmo_d;
         instret_q  <= instret_d;
         halted_q   <= halted_d;
         error_q    <= error_d;
         err_code_q <= err_code_d;
      end
   end

   assign state    = state_q;
   assign ir       = ir_q;
   assign instret  = instret_q;
   assign halted   = halted_q;
   assign error    = error_q;
   assign err_code = err_code_q;

endmodule
